// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - two-requester scheduler sharing one CORDIC core
// Round-robin arbitration over 1-entry slots, with timeout abort to a NaN result.
module cordic_sched #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] NAN_WORD = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        r0_start,
  input  logic [31:0] r0_x,
  output logic        r0_busy,
  output logic        r0_done,
  output logic [31:0] r0_result,
  output logic        r0_err,
  input  logic        r1_start,
  input  logic [31:0] r1_x,
  output logic        r1_busy,
  output logic        r1_done,
  output logic [31:0] r1_result,
  output logic        r1_err,
  output logic        core_clk_en,
  output logic        core_start,
  output logic [31:0] core_x,
  input  logic [31:0] core_result,
  input  logic        core_done
);

  localparam int          CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          pend0, pend1;
  logic [31:0]   x0, x1;
  logic          ptr;
  logic          gnt;
  logic          abort;
  logic [CW-1:0] cnt;
  logic [31:0]   res_q;
  logic          done0_q, done1_q, err0_q, err1_q, cstart_q;
  logic          sel;
  logic          accept0, accept1;

  // Pulse outputs are gated so a frozen scheduler shows no activity, yet the
  // held registers let the pulse reappear once clk_en returns.
  assign r0_done     = done0_q & clk_en;
  assign r1_done     = done1_q & clk_en;
  assign r0_err      = err0_q & clk_en;
  assign r1_err      = err1_q & clk_en;
  assign core_start  = cstart_q & clk_en;
  assign core_clk_en = clk_en;

  // busy stays up through the done cycle so a restart lands one cycle later.
  assign r0_busy = pend0 | done0_q;
  assign r1_busy = pend1 | done1_q;

  assign accept0 = clk_en & r0_start & ~r0_busy;
  assign accept1 = clk_en & r1_start & ~r1_busy;

  always_comb begin
    sel = 1'b0;
    if (pend0 && pend1) sel = ptr;
    else                sel = ~pend0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      x0        <= 32'h0;
      x1        <= 32'h0;
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      abort     <= 1'b0;
      cnt       <= '0;
      res_q     <= 32'h0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      cstart_q  <= 1'b0;
      core_x    <= 32'h0;
      r0_result <= 32'h0;
      r1_result <= 32'h0;
    end else if (clk_en) begin
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      cstart_q <= 1'b0;
      if (accept0) begin
        pend0 <= 1'b1;
        x0    <= r0_x;
      end
      if (accept1) begin
        pend1 <= 1'b1;
        x1    <= r1_x;
      end
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            gnt      <= sel;
            ptr      <= ~sel;
            core_x   <= sel ? x1 : x0;
            cstart_q <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          abort <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the final count still wins over the abort.
          if (core_done) begin
            res_q <= core_result;
            state <= RESP;
          end else if (cnt == TMAX) begin
            res_q <= NAN_WORD;
            abort <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (gnt) begin
            done1_q   <= 1'b1;
            err1_q    <= abort;
            r1_result <= res_q;
            pend1     <= 1'b0;
          end else begin
            done0_q   <= 1'b1;
            err0_q    <= abort;
            r0_result <= res_q;
            pend0     <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
